ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Parametrised successor to the keyboard/produce pair: a single block that receives PS/2 frames, buffers scan bytes in a FIFO, and decodes make/break/extended (E0) prefixes.
- Presents decoded key events on a ready/valid interface and tracks the currently held key and a press counter.
- Sits between the PS/2 pins and display/ASCII logic at top level.

Parameters:
- FIFO_DEPTH, 8, scan-byte FIFO entries; power of two, >=2.
- COUNT_W, 8, press_count width.
- TIMEOUT_CYC, 50000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-high (asserted = 1), despite the name.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- evt_valid  out  1  decoded event available.
- evt_ready  in  1  consumer accepts the event.
- evt_code  out  8  scan code of the event, prefixes stripped.
- evt_ext  out  1  event was E0-prefixed.
- evt_break  out  1  event was F0 (release).
- key_held  out  1  a key is currently held.
- key_code  out  8  code of the held or last-held key.
- key_ext  out  1  extended flag of key_code.
- press_count  out  COUNT_W  new key presses, wraps.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse on a bad frame.

Behaviour:
- Reset: every output is 0. FIFO is emptied, decoder goes to IDLE, and the receiver bit counter returns to 0. This applies mid-frame and mid-handshake; no partial frame survives reset.
- Sync: ps2_clk and ps2_data each pass through a 2-flop synchroniser. A falling edge is detected from a third ps2_clk flop, and data is sampled in the detect cycle.
- Frame format: 11 bits = start 0, 8 data bits LSB first, odd parity, stop 1.
- Frame valid: start 0, parity odd over data+parity, stop 1. The byte is pushed into the FIFO in the cycle after the stop-bit detect cycle.
- Frame invalid: frame_err pulses for 1 cycle at the same point, and the byte is discarded.
- Timeout: if the bit counter is non-zero and TIMEOUT_CYC cycles pass with no falling edge, the counter clears silently (no frame_err).
- FIFO full:
  - A push while full is dropped and overflow is set (sticky until reset).
  - A push and a pop in the same cycle while full both succeed; no drop.
- Decoder FSM states: IDLE, E0, F0, E0F0. It pops one byte per cycle when the FIFO is non-empty and the output register is empty or being accepted (evt_valid & evt_ready).
  - IDLE: E0 -> E0; F0 -> F0; other -> emit {ext=0, break=0}.
  - E0: F0 -> E0F0; E0 -> stay; other -> emit {1,0}, go to IDLE.
  - F0: other -> emit {0,1}, go to IDLE. E0/F0 received here -> silently return to IDLE.
  - E0F0: other -> emit {1,1}, go to IDLE. E0/F0 received here -> silently return to IDLE.
- Output register and handshake:
  - Emitted events load the output register and evt_valid rises the next cycle.
  - evt_* are held stable while evt_valid & !evt_ready.
  - Back-to-back events are accepted every cycle when evt_ready=1.
- Latency: with FIFO and output empty, evt_valid rises exactly 3 cycles after the stop-bit detect cycle of the final byte (push, pop/decode, register).
- Key tracking, updated in the cycle an event is emitted (independent of evt_ready):
  - Make with (!key_held or {ext,code}!={key_ext,key_code}): press_count+1 (mod 2^COUNT_W), key_code/key_ext load, key_held=1.
  - Make equal to the held key (typematic repeat): no change.
  - Break equal to the held key: key_held=0, key_code retained.
  - Break of any other key: ignored.

Decomposition:
- Package ps2_pkg:
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - decoder state enum;
  - event struct {ext, brk, code}.
- Sub-module ps2_rx_frame: synchroniser, edge detect, shift register, parity/stop check and timeout. Outputs byte_valid pulse, byte, frame_err.
- FIFO and decoder stay in the top module.

Test Plan:
- Send frame 0x1C, evt_ready=1 -> one event {code=1C, ext=0, brk=0} at exactly 3 cycles post-stop; key_held=1, key_code=1C, press_count=1.
- Send F0,1C -> event {1C, brk=1}; key_held=0, key_code stays 1C, press_count stays 1.
- Send E0,75 then E0,F0,75 -> events {75, ext=1, brk=0} then {75, ext=1, brk=1}; press_count +1 only.
- Send 1C, 1C, 1C (typematic) -> 3 events, press_count +1 only. Then 1B -> press_count +1, key_code=1B.
- Send 0x1C with even parity -> frame_err single pulse, no event. Then abort after 4 bits and wait TIMEOUT_CYC; the next good frame 0x32 decodes correctly.
- Hold evt_ready=0 and send FIFO_DEPTH+2 make codes -> overflow=1; evt_* stable. Then release evt_ready -> exactly FIFO_DEPTH+1 events in order (1 in the output register + FIFO_DEPTH buffered). Assert rst_n mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key tracker.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    StIdle,
    StE0,
    StF0,
    StE0F0
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the pins, shifts in 11-bit frames and
// reports each byte as a one-cycle pulse, or a frame_err pulse on a bad frame.
module ps2_rx_frame #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q;
  logic          fall, bit_in;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    rx_byte_q;

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = data_sync_q[1];

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    timer_d      = timer_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall) begin
      timer_d = '0;
      if (bit_cnt_q == 4'd10) begin
        // shift_q holds start in [0], data in [8:1], parity in [9]; bit_in is stop
        bit_cnt_d = '0;
        if (!shift_q[0] && (^shift_q[9:1]) && bit_in) begin
          byte_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = {bit_in, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d = '0;
        timer_d   = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      clk_sync_q   <= 2'b11;
      data_sync_q  <= 2'b11;
      clk_prev_q   <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      timer_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_byte_q    <= '0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk};
      data_sync_q  <= {data_sync_q[0], ps2_data};
      clk_prev_q   <= clk_sync_q[1];
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      timer_q      <= timer_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      if (byte_valid_d) begin
        rx_byte_q <= shift_q[8:1];
      end
    end
  end

  assign byte_valid = byte_valid_q;
  assign rx_byte    = rx_byte_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: receiver, scan-byte FIFO, make/break/E0 decoder, event
// output register with ready/valid, and held-key / press-count tracking.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [7:0]         evt_code,
  output logic               evt_ext,
  output logic               evt_break,
  output logic               key_held,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic [COUNT_W-1:0] press_count,
  output logic               overflow,
  output logic               frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic       rx_valid;
  logic [7:0] rx_byte;

  ps2_rx_frame #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  // Scan-byte FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full, push, pop;
  logic [7:0]  head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = fifo_q[rd_ptr_q[AW-1:0]];

  logic evt_valid_q, evt_valid_d;
  assign pop  = !fifo_empty && (!evt_valid_q || evt_ready);
  assign push = rx_valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= rx_byte;
    end
  end

  dec_state_e state_q, state_d;
  logic       emit;
  ps2_evt_t   emit_evt;

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_evt = '{ext: 1'b0, brk: 1'b0, code: head};
    if (pop) begin
      unique case (state_q)
        StIdle: begin
          if (head == PS2_EXT)      state_d = StE0;
          else if (head == PS2_BRK) state_d = StF0;
          else                      emit = 1'b1;
        end
        StE0: begin
          if (head == PS2_BRK) begin
            state_d = StE0F0;
          end else if (head != PS2_EXT) begin
            emit         = 1'b1;
            emit_evt.ext = 1'b1;
            state_d      = StIdle;
          end
        end
        StF0: begin
          state_d = StIdle;
          if (head != PS2_EXT && head != PS2_BRK) begin
            emit         = 1'b1;
            emit_evt.brk = 1'b1;
          end
        end
        StE0F0: begin
          state_d = StIdle;
          if (head != PS2_EXT && head != PS2_BRK) begin
            emit         = 1'b1;
            emit_evt.ext = 1'b1;
            emit_evt.brk = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  ps2_evt_t           evt_q, evt_d;
  logic               key_held_q, key_held_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_ext_q, key_ext_d;
  logic [COUNT_W-1:0] press_q, press_d;
  logic               overflow_d, overflow_q;

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_d       = evt_q;
    key_held_d  = key_held_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    press_d     = press_q;
    overflow_d  = overflow_q | (rx_valid & fifo_full & ~pop);
    if (emit) begin
      evt_valid_d = 1'b1;
      evt_d       = emit_evt;
    end else if (evt_ready) begin
      evt_valid_d = 1'b0;
    end
    // Tracking follows decode, not consumer acceptance.
    if (emit) begin
      if (!emit_evt.brk) begin
        if (!key_held_q || {emit_evt.ext, emit_evt.code} != {key_ext_q, key_code_q}) begin
          press_d    = press_q + COUNT_W'(1);
          key_code_d = emit_evt.code;
          key_ext_d  = emit_evt.ext;
          key_held_d = 1'b1;
        end
      end else if (key_held_q && {emit_evt.ext, emit_evt.code} == {key_ext_q, key_code_q}) begin
        key_held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= StIdle;
      evt_valid_q <= 1'b0;
      evt_q       <= '0;
      key_held_q  <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      press_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_q       <= evt_d;
      key_held_q  <= key_held_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      press_q     <= press_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_q.code;
  assign evt_ext     = evt_q.ext;
  assign evt_break   = evt_q.brk;
  assign key_held    = key_held_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign press_count = press_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: table of key sequences plus hand-written corner cases,
// with an event scoreboard fed at stimulus time and drained by a monitor.
module tb_ps2_key_tracker;

  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned COUNT_W     = 8;
  localparam int unsigned TIMEOUT_CYC = 1000;
  localparam int HALF = 4;
  localparam int GAP  = 20;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               ps2_clk = 1'b1;
  logic               ps2_data = 1'b1;
  logic               evt_valid, evt_ready = 1'b1;
  logic [7:0]         evt_code;
  logic               evt_ext, evt_break;
  logic               key_held;
  logic [7:0]         key_code;
  logic               key_ext;
  logic [COUNT_W-1:0] press_count;
  logic               overflow, frame_err;

  ps2_key_tracker #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .COUNT_W    (COUNT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_break  (evt_break),
    .key_held   (key_held),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .press_count(press_count),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  logic [9:0] exp_q[$];
  bit         stall = 1'b0;
  logic [9:0] stall_evt = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [9:0] ev(input logic ext, input logic brk, input logic [7:0] code);
    return {ext, brk, code};
  endfunction

  // Monitor: pops the scoreboard on each accepted event, checks stability on stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      stall = 1'b0;
    end else begin
      if (frame_err) fe_cnt++;
      if (stall) check("hold", {evt_valid, evt_ext, evt_break, evt_code}, {1'b1, stall_evt});
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_evt: got %0h, expected none", {evt_ext, evt_break, evt_code});
        end else begin
          check("evt", {evt_ext, evt_break, evt_code}, exp_q.pop_front());
        end
      end
      stall     = evt_valid && !evt_ready;
      stall_evt = {evt_ext, evt_break, evt_code};
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 evt_ready = r;
  endtask

  task automatic set_rst(input logic r);
    @(posedge clk);
    #1 rst_n = r;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    wait_cyc(4);
    check({nm, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_key(input string nm, input logic held, input logic [7:0] kc,
                           input logic ke, input logic [7:0] pc);
    check({nm, "_held"}, key_held, held);
    check({nm, "_code"}, key_code, kc);
    check({nm, "_ext"}, key_ext, ke);
    check({nm, "_press"}, press_count, pc);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic [7:0] code;
    logic       ext, brk, held;
    logic [7:0] kcode;
    logic       kext;
    logic [7:0] press;
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, t;
    vecs[0]  = '{8'hF0, 8'h1C, 8'h00, 2, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0, 8'd1};
    vecs[1]  = '{8'hE0, 8'h75, 8'h00, 2, 8'h75, 1'b1, 1'b0, 1'b1, 8'h75, 1'b1, 8'd2};
    vecs[2]  = '{8'hE0, 8'hF0, 8'h75, 3, 8'h75, 1'b1, 1'b1, 1'b0, 8'h75, 1'b1, 8'd2};
    vecs[3]  = '{8'h1C, 8'h00, 8'h00, 1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd3};
    vecs[4]  = '{8'h1C, 8'h00, 8'h00, 1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd3};
    vecs[5]  = '{8'h1C, 8'h00, 8'h00, 1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd3};
    vecs[6]  = '{8'h1B, 8'h00, 8'h00, 1, 8'h1B, 1'b0, 1'b0, 1'b1, 8'h1B, 1'b0, 8'd4};
    vecs[7]  = '{8'hF0, 8'hE0, 8'h2C, 3, 8'h2C, 1'b0, 1'b0, 1'b1, 8'h2C, 1'b0, 8'd5};
    vecs[8]  = '{8'hE0, 8'hE0, 8'h4A, 3, 8'h4A, 1'b1, 1'b0, 1'b1, 8'h4A, 1'b1, 8'd6};
    vecs[9]  = '{8'hF0, 8'h2C, 8'h00, 2, 8'h2C, 1'b0, 1'b1, 1'b1, 8'h4A, 1'b1, 8'd6};
    vecs[10] = '{8'hE0, 8'hF0, 8'h4A, 3, 8'h4A, 1'b1, 1'b1, 1'b0, 8'h4A, 1'b1, 8'd6};

    // Reset state
    wait_cyc(5);
    check("reset_outputs", {evt_valid, evt_code, evt_ext, evt_break, key_held, key_code,
                            key_ext, press_count, overflow, frame_err}, 32'd0);
    set_rst(1'b0);
    wait_cyc(5);

    // First make code with exact latency from the stop-bit edge
    exp_q.push_back(ev(1'b0, 1'b0, 8'h1C));
    send_frame(8'h1C, 1'b0, 10);
    ps2_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("latency_early", evt_valid, 1'b0);
    @(posedge clk);
    #1 check("latency_on_time", evt_valid, 1'b1);
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(GAP);
    drain("first");
    check_key("first", 1'b1, 8'h1C, 1'b0, 8'd1);

    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(ev(vecs[i].ext, vecs[i].brk, vecs[i].code));
      send_frame(vecs[i].b0, 1'b0, 11);
      if (vecs[i].n > 1) send_frame(vecs[i].b1, 1'b0, 11);
      if (vecs[i].n > 2) send_frame(vecs[i].b2, 1'b0, 11);
      drain($sformatf("vec%0d", i));
      check_key($sformatf("vec%0d", i), vecs[i].held, vecs[i].kcode, vecs[i].kext,
                vecs[i].press);
    end

    // Bad parity: one frame_err pulse, no event
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 11);
    wait_cyc(10);
    check("parity_err_pulse", fe_cnt - fe0, 1);
    check_key("parity_err", 1'b0, 8'h4A, 1'b1, 8'd6);

    // Abandoned partial frame clears silently after the timeout
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, 4);
    wait_cyc(TIMEOUT_CYC + 50);
    exp_q.push_back(ev(1'b0, 1'b0, 8'h32));
    send_frame(8'h32, 1'b0, 11);
    drain("timeout");
    check("timeout_no_err", fe_cnt - fe0, 0);
    check_key("timeout", 1'b1, 8'h32, 1'b0, 8'd7);

    // Overflow with a stalled consumer
    set_ready(1'b0);
    for (int k = 0; k < FIFO_DEPTH + 2; k++) begin
      if (k < FIFO_DEPTH + 1) exp_q.push_back(ev(1'b0, 1'b0, 8'h15 + 8'(k)));
      send_frame(8'h15 + 8'(k), 1'b0, 11);
      if (k == FIFO_DEPTH) check("overflow_not_yet", overflow, 1'b0);
    end
    wait_cyc(5);
    check("overflow_set", overflow, 1'b1);
    check("stall_evt", {evt_valid, evt_ext, evt_break, evt_code}, {1'b1, ev(1'b0, 1'b0, 8'h15)});
    set_ready(1'b1);
    drain("overflow");
    check_key("overflow", 1'b1, 8'h1D, 1'b0, 8'd16);
    check("overflow_sticky", overflow, 1'b1);

    // Reset mid-handshake and mid-frame
    set_ready(1'b0);
    send_frame(8'h2B, 1'b0, 11);
    t = 0;
    while (!evt_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("pre_reset_valid", evt_valid, 1'b1);
    send_frame(8'h3A, 1'b0, 5);
    set_rst(1'b1);
    wait_cyc(3);
    check("midreset_outputs", {evt_valid, evt_code, evt_ext, evt_break, key_held, key_code,
                               key_ext, press_count, overflow, frame_err}, 32'd0);
    set_rst(1'b0);
    set_ready(1'b1);
    wait_cyc(5);
    fe0 = fe_cnt;
    exp_q.push_back(ev(1'b0, 1'b0, 8'h1C));
    send_frame(8'h1C, 1'b0, 11);
    drain("post_reset");
    check_key("post_reset", 1'b1, 8'h1C, 1'b0, 8'd1);
    check("post_reset_no_err", fe_cnt - fe0, 0);
    check("post_reset_overflow", overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
